// File: rtl/ser_pkg.sv
// Shared types and constants for the serial frame deserializer slice.
package ser_pkg;

    // Frame assembly states; PARITY is only reachable with the parity-check build.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_WIDTH = 8;

    // Bit-order encodings for msb_first.
    localparam logic MSB_FIRST = 1'b1;
    localparam logic LSB_FIRST = 1'b0;

endpackage : ser_pkg

// File: rtl/serial_frame_deserializer_if.sv
// Serial-in / parallel-out bundle between the shift-register stream, the
// deserializer and the parallel consumer.
interface serial_frame_deserializer_if #(
    parameter int unsigned WIDTH = ser_pkg::DEFAULT_WIDTH
);
    logic             bit_in;
    logic             bit_valid;
    logic             msb_first;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             overflow;
    logic             par_err;

    // Stream producer / parallel consumer side.
    modport master (
        output bit_in, bit_valid, msb_first, out_ready,
        input  out_data, out_valid, overflow, par_err
    );

    // Deserializer side.
    modport slave (
        input  bit_in, bit_valid, msb_first, out_ready,
        output out_data, out_valid, overflow, par_err
    );
endinterface : serial_frame_deserializer_if

// File: rtl/serial_frame_deserializer_hold_reg.sv
// Single-entry valid/ready holding register for completed frames.
// A frame arriving while the entry is full and not draining is dropped and
// flagged with a one-cycle overflow pulse; drain and fill on the same edge
// replace the entry without a bubble.
module deser_hold_reg #(
    parameter int unsigned WIDTH = ser_pkg::DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_err,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             overflow,
    output logic             par_err
);
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;

    // Load, drop or drain decision for the holding entry.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovf_d   = 1'b0;
        err_d   = err_q;
        if (in_valid) begin
            if (!valid_q || out_ready) begin
                data_d  = in_data;
                err_d   = in_err;
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Holding register state.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign overflow  = ovf_q;
    assign par_err   = err_q;

endmodule : deser_hold_reg

// File: rtl/serial_frame_deserializer.sv
// Packs WIDTH consecutive valid serial bits into a parallel word and hands it
// to a single-entry valid/ready holding register.
// Optional feature: define SER_PARITY_CHECK_EN to expect one even-parity bit
// after the data bits and report par_err alongside the word.
module serial_frame_deserializer
    import ser_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    serial_frame_deserializer_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             msb_q, msb_d;

    logic             order_c;
    logic [WIDTH-1:0] shifted_c;
    logic             frame_done_c;
    logic [WIDTH-1:0] frame_word_c;
    logic             frame_err_c;

    // Bit order comes from the live input on a frame's first bit, latched value after.
    always_comb begin
        order_c = (state_q == IDLE) ? bus.msb_first : msb_q;
        if (order_c == MSB_FIRST) begin
            shifted_c = {shreg_q[WIDTH-2:0], bus.bit_in};
        end else begin
            shifted_c = {bus.bit_in, shreg_q[WIDTH-1:1]};
        end
    end

    // Next-state, counter and shift-register update; flags frame completion.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shreg_d      = shreg_q;
        msb_d        = msb_q;
        frame_done_c = 1'b0;
        frame_word_c = shreg_q;
        frame_err_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.bit_valid) begin
                    shreg_d = shifted_c;
                    cnt_d   = CNT_W'(1);
                    msb_d   = bus.msb_first;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.bit_valid) begin
                    shreg_d = shifted_c;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef SER_PARITY_CHECK_EN
                        cnt_d   = CNT_W'(WIDTH);
                        state_d = PARITY;
`else
                        cnt_d        = '0;
                        state_d      = IDLE;
                        frame_done_c = 1'b1;
                        frame_word_c = shifted_c;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
`ifdef SER_PARITY_CHECK_EN
            PARITY: begin
                // Data word is complete in shreg_q; this bit is the even-parity bit.
                if (bus.bit_valid) begin
                    cnt_d        = '0;
                    state_d      = IDLE;
                    frame_done_c = 1'b1;
                    frame_word_c = shreg_q;
                    frame_err_c  = (^shreg_q) ^ bus.bit_in;
                end
            end
`endif
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Frame assembly state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            msb_q   <= MSB_FIRST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            msb_q   <= msb_d;
        end
    end

    deser_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (frame_done_c),
        .in_data   (frame_word_c),
        .in_err    (frame_err_c),
        .out_ready (bus.out_ready),
        .out_data  (bus.out_data),
        .out_valid (bus.out_valid),
        .overflow  (bus.overflow),
        .par_err   (bus.par_err)
    );

endmodule : serial_frame_deserializer

// File: tb/tb_serial_frame_deserializer.sv
// Bench for serial_frame_deserializer (WIDTH=8): vector table plus hand-written
// corner sequences, with a scoreboard checking every handshake transfer.
module tb_serial_frame_deserializer;

`ifdef SER_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    serial_frame_deserializer_if #(.WIDTH(8)) bus ();

    serial_frame_deserializer #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       e;
    } exp_t;

    typedef struct {
        logic       msb;
        logic [7:0] seq;       // arrival order: seq[7] first
        logic       par_flip;  // send wrong parity (parity build only)
        int         gap;       // idle cycles after each bit
        logic [7:0] exp_data;
        logic       exp_err;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[8];
    int   n_cmp = 0;
    int   n_err = 0;
    int   ovf_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: one transfer per negedge with out_valid && out_ready.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_unexpected: got %0h expected none", bus.out_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_data", 32'(bus.out_data), 32'(e.d));
                check("sb_par_err", 32'(bus.par_err), 32'(e.e));
            end
        end
        if (!rst && bus.overflow) ovf_cnt++;
    end

    task automatic drive_bit(input logic b, input logic m, input int gap);
        bus.bit_in    = b;
        bus.bit_valid = 1'b1;
        bus.msb_first = m;
        @(posedge clk); #1;
        bus.bit_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    // Sends a whole frame; the frame-ending bit has no trailing gap.
    task automatic send_frame(input logic [7:0] seq, input logic m, input logic flip,
                              input int gap, input logic rdy_end);
        for (int i = 7; i >= 0; i--) begin
            if (i == 0 && !PAR_EN && rdy_end) bus.out_ready = 1'b1;
            drive_bit(seq[i], m, (i == 0 && !PAR_EN) ? 0 : gap);
        end
        if (PAR_EN) begin
            if (rdy_end) bus.out_ready = 1'b1;
            drive_bit((^seq) ^ flip, m, 0);
        end
        if (rdy_end) bus.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ovf0;
        vecs[0] = '{1'b1, 8'hB2, 1'b0, 0, 8'hB2, 1'b0};
        vecs[1] = '{1'b0, 8'hB2, 1'b0, 0, 8'h4D, 1'b0};
        vecs[2] = '{1'b1, 8'hA5, 1'b1, 0, 8'hA5, 1'b1};
        vecs[3] = '{1'b0, 8'h01, 1'b0, 0, 8'h80, 1'b0};
        vecs[4] = '{1'b1, 8'hFF, 1'b0, 2, 8'hFF, 1'b0};
        vecs[5] = '{1'b0, 8'h0F, 1'b1, 0, 8'hF0, 1'b1};
        vecs[6] = '{1'b1, 8'h00, 1'b0, 1, 8'h00, 1'b0};
        vecs[7] = '{1'b0, 8'h6E, 1'b0, 0, 8'h76, 1'b0};

        rst = 1'b1;
        bus.bit_in = 1'b0;
        bus.bit_valid = 1'b0;
        bus.msb_first = 1'b1;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        check("rst_par_err", 32'(bus.par_err), 32'd0);

        // Table: consumer always ready, frames back-to-back where gap=0.
        bus.out_ready = 1'b1;
        foreach (vecs[k]) begin
            sb.push_back('{vecs[k].exp_data, PAR_EN ? vecs[k].exp_err : 1'b0});
            send_frame(vecs[k].seq, vecs[k].msb, vecs[k].par_flip, vecs[k].gap, 1'b0);
            check("vec_latency_valid", 32'(bus.out_valid), 32'd1);
            check("vec_data", 32'(bus.out_data), 32'(vecs[k].exp_data));
        end
        @(posedge clk); #1;

        // msb_first toggled mid-frame is ignored until the next frame.
        sb.push_back('{8'h4D, 1'b0});
        for (int i = 7; i >= 0; i--) drive_bit(8'hB2 >> i, (i >= 5) ? 1'b0 : 1'b1, 0);
        if (PAR_EN) drive_bit(^8'hB2, 1'b1, 0);
        check("toggle_data", 32'(bus.out_data), 32'h4D);
        @(posedge clk); #1;

        // Holding full, second frame dropped with one overflow pulse.
        bus.out_ready = 1'b0;
        ovf0 = ovf_cnt;
        sb.push_back('{8'hA5, 1'b0});
        send_frame(8'hA5, 1'b1, 1'b0, 0, 1'b0);
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        send_frame(8'h3C, 1'b1, 1'b0, 0, 1'b0);
        @(posedge clk); #1;
        check("drop_data", 32'(bus.out_data), 32'hA5);
        check("drop_valid", 32'(bus.out_valid), 32'd1);
        check("drop_ovf_pulses", 32'(ovf_cnt - ovf0), 32'd1);

        // Drain and fill on the same edge: no overflow, no bubble.
        sb.push_back('{8'h3C, 1'b0});
        send_frame(8'h3C, 1'b1, 1'b0, 0, 1'b1);
        check("swap_valid", 32'(bus.out_valid), 32'd1);
        check("swap_data", 32'(bus.out_data), 32'h3C);
        @(posedge clk); #1;
        check("swap_no_ovf", 32'(ovf_cnt - ovf0), 32'd1);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("drain_valid", 32'(bus.out_valid), 32'd0);
        check("drain_data_kept", 32'(bus.out_data), 32'h3C);

        // Reset mid-frame discards the held word and the partial frame.
        bus.out_ready = 1'b0;
        send_frame(8'h5A, 1'b1, 1'b0, 0, 1'b0);
        ovf0 = ovf_cnt;
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b1, 2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_data", 32'(bus.out_data), 32'd0);
        check("mid_rst_overflow", 32'(bus.overflow), 32'd0);
        check("mid_rst_par_err", 32'(bus.par_err), 32'd0);
        bus.out_ready = 1'b1;
        sb.push_back('{8'h01, 1'b0});
        send_frame(8'h01, 1'b1, 1'b0, 2, 1'b0);
        check("post_rst_valid", 32'(bus.out_valid), 32'd1);
        check("post_rst_data", 32'(bus.out_data), 32'h01);
        check("post_rst_no_ovf", 32'(ovf_cnt - ovf0), 32'd0);
        @(posedge clk); #1;

`ifdef SER_PARITY_CHECK_EN
        // Parity good then bad on the same data word.
        sb.push_back('{8'hB2, 1'b0});
        send_frame(8'hB2, 1'b1, 1'b0, 0, 1'b0);
        check("par_good_err", 32'(bus.par_err), 32'd0);
        sb.push_back('{8'hB2, 1'b1});
        send_frame(8'hB2, 1'b1, 1'b1, 0, 1'b0);
        check("par_bad_valid", 32'(bus.out_valid), 32'd1);
        check("par_bad_err", 32'(bus.par_err), 32'd1);
        @(posedge clk); #1;
`endif

        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_serial_frame_deserializer
